// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_tx_if
//  Description : Handshake / serial bus bundle for the PISO transmit shifter.
//                Groups the parallel load handshake, the direction and enable
//                controls and the serial output side into one interface.
//
//  Parameters  : WIDTH - parallel word width in bits (WIDTH >= 2)
//
//  Signals     : load_data   [WIDTH] parallel word to transmit
//                load_valid  [1]     load_data is valid
//                load_ready  [1]     shifter can accept a word
//                dir         [1]     0 = MSB-first, 1 = LSB-first
//                en          [1]     shift enable, one bit per enabled cycle
//                sout        [1]     registered serial data
//                sout_valid  [1]     sout carries a frame bit
//                done        [1]     one-cycle end-of-frame pulse
//
//  Modports    : master - word producer / serial consumer side
//                slave  - the shifter itself
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             dir;
    logic             en;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load_data,
        output load_valid,
        output dir,
        output en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        input  dir,
        input  en,
        output load_ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_tx
//  Description : Parallel-in serial-out transmit shifter. Accepts a WIDTH-bit
//                word through a valid/ready handshake and emits it one bit per
//                enabled cycle, MSB-first (dir=0) or LSB-first (dir=1). A
//                receiver using the same dir and en timing rebuilds the word.
//
//  Parameters  : WIDTH - data word width in bits, WIDTH >= 2 (default 8)
//
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous reset, active-high
//                bus  - piso_shift_tx_if.slave:
//                       load_data/load_valid/load_ready : word handshake
//                       dir : bit order, sampled only at accept
//                       en  : shift enable
//                       sout/sout_valid : registered serial output
//                       done : one-cycle pulse after the last bit is consumed
//
//  Build macro : PISO_PARITY_EN - when defined, an even-parity bit (^word) is
//                appended after the data bits, making a frame WIDTH+1 enabled
//                cycles. When undefined the parity state and logic are absent.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    piso_shift_tx_if.slave     bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef PISO_PARITY_EN
        ,
        S_PAR   = 2'd2
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dir_q;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_done;
`ifdef PISO_PARITY_EN
    logic               r_par;
`endif

    // ------------------------------------------------------------------------
    // Combinational handshake
    // ------------------------------------------------------------------------
    logic w_load_ready;
    logic w_accept;

    // Ready depends only on state, so an accept is possible in the done
    // cycle (state has already returned to IDLE), giving a one-cycle gap.
    assign w_load_ready = (r_state == S_IDLE);
    assign w_accept     = bus.load_valid & w_load_ready;

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.load_ready = w_load_ready;
    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.done       = r_done;

    // ------------------------------------------------------------------------
    // FSM and datapath
    //
    // sout is registered: whenever the shift register changes, the bit that
    // will sit at the output end afterwards is loaded into r_sout in the same
    // edge. That keeps sout equal to shreg[WIDTH-1] (MSB-first) or shreg[0]
    // (LSB-first) throughout SHIFT without a combinational output path.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_dir_q      <= 1'b0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse unless re-asserted below.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg      <= bus.load_data;
                        r_dir_q      <= bus.dir;
                        r_cnt        <= '0;
                        r_state      <= S_SHIFT;
                        r_sout       <= bus.dir ? bus.load_data[0]
                                                : bus.load_data[WIDTH-1];
                        r_sout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
                        r_par        <= ^bus.load_data;
`endif
                    end
                end

                S_SHIFT: begin
                    if (bus.en) begin
                        if (r_cnt == c_LAST) begin
                            // Last data bit consumed.
`ifdef PISO_PARITY_EN
                            r_state      <= S_PAR;
                            r_sout       <= r_par;
`else
                            r_state      <= S_IDLE;
                            r_sout       <= 1'b0;
                            r_sout_valid <= 1'b0;
                            r_done       <= 1'b1;
`endif
                        end else begin
                            // Shift toward the output end; the vacated bit
                            // is zero-filled. The next output bit is the
                            // neighbour of the current one.
                            if (r_dir_q) begin
                                r_shreg <= r_shreg >> 1;
                                r_sout  <= r_shreg[1];
                            end else begin
                                r_shreg <= r_shreg << 1;
                                r_sout  <= r_shreg[WIDTH-2];
                            end
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

`ifdef PISO_PARITY_EN
                S_PAR: begin
                    if (bus.en) begin
                        r_state      <= S_IDLE;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end
`endif

                default: begin
                    // Unreachable encodings recover to an idle, quiet output.
                    r_state      <= S_IDLE;
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
